sd_acmd41_ready: RTL
====================

// Module: sd_acmd41_ready
// PURPOSE
// Next SD-over-SPI init stage after the CMD0/CMD8 sequencer, started once CMD8 returns R1=0x01.
// Repeats CMD55+ACMD41 (HCS=1) until the card leaves idle (R1=0x00), then issues CMD58 and captures OCR/CCS.
// Generates SCLK from the system clock; owns CS/MOSI for its duration.
// PARAMETERS
// CLK_DIV    100    input_clk cycles per SCLK half-period (50 MHz -> 250 kHz)
// MAX_TRIES  1000   ACMD41 attempts before TIMEOUT error (16-bit)
// NCR_BITS   64     idle MISO bits tolerated before R1 start bit -> NORESP error
// GAP_BITS   8      SCLK cycles with CS=1, MOSI=1 between commands
// PORTS
// input_clk  in   1   system clock; all logic on posedge
// input_rst  in   1   synchronous, active-high reset
// start      in   1   1-cycle pulse; accepted only when busy=0
// MISO_bit   in   1   card data out
// SCLK_bit   out  1   SPI clock, mode 0, idles low
// CS_bit     out  1   chip select, active low
// MOSI_bit   out  1   card data in; 1 when not transmitting a command
// busy       out  1   high from cycle after accepted start until done/error
// done       out  1   level; success, held until next start/reset
// error      out  1   level; failure, held until next start/reset
// err_code   out  2   0 none, 1 NORESP, 2 BADR1, 3 TIMEOUT
// ocr        out  32  OCR from CMD58; valid when done=1
// ccs        out  1   ocr[30] (1 = SDHC/SDXC block addressing)
// tries      out  16  ACMD41 attempts so far (1 after first)
// BEHAVIOUR
// Reset: SCLK_bit=0 CS_bit=1 MOSI_bit=1 busy=0 done=0 error=0 err_code=0 ocr=0 ccs=0 tries=0, state IDLE,
//   divider cleared. Reset mid-command aborts at once: CS=1, SCLK=0 the next cycle, no pending edges.
// SCLK: divider counts 0..CLK_DIV-1; at wrap SCLK toggles. Rise edge: sample MISO. Fall edge: update MOSI.
//   Bit period = 2*CLK_DIV input_clk cycles. SCLK runs only while busy; stops low in DONE/FAIL/IDLE.
// Frames (48 bit, MSB first): CMD55=0x770000000065, ACMD41=0x694000000077, CMD58=0x7A00000000FD.
//   First bit on MOSI on the cycle CS falls (before first rise edge); 48 rise edges per frame.
// R1 capture: after frame, MOSI=1; scan sampled bits; first 0 starts R1; R1 = that bit + next 7 (MSB first).
//   NCR_BITS consecutive 1s with no start bit -> FAIL, err_code=1.
// FSM: IDLE -start-> TX55 -> R55 -> GAP -> TX41 -> R41 -> {GAP->TX55 | GAP->TX58 | FAIL} ; TX58 -> R58 -> OCR -> DONE.
//   R55: R1 in {0x00,0x01} -> GAP; else FAIL err_code=2.
//   R41: tries+=1 on R1 capture; 0x00 -> GAP then TX58; 0x01 and tries<MAX_TRIES -> GAP then TX55;
//     0x01 and tries==MAX_TRIES -> FAIL err_code=3; other -> FAIL err_code=2.
//   R58: R1!=0x00 -> FAIL err_code=2; else OCR shifts in next 32 sampled bits MSB first.
//   OCR: after 32nd bit, ocr and ccs=ocr[30] register; 8 trailing SCLKs with CS=1; then DONE.
//   GAP: CS=1, MOSI=1, GAP_BITS SCLK cycles.
// DONE/FAIL: CS=1, busy=0, done/error asserted same cycle busy drops; start here clears done, error,
//   err_code, tries, ocr, ccs and re-enters TX55. start while busy=1 ignored.
// tries saturates at MAX_TRIES; never wraps.
// TESTING (bench: behavioural SPI card model on SCLK edges, CLK_DIV=2 for speed)
// 1 card answers CMD55 0x01, ACMD41 0x01 x3 then 0x00, CMD58 0x00 + OCR 0xC0FF8000 -> done=1, tries=4,
//   ocr=0xC0FF8000, ccs=1; MOSI frames byte-exact vs constants above.
// 2 MAX_TRIES=5, ACMD41 always 0x01 -> error=1, err_code=3, tries=5, exactly 5 ACMD41 frames, CS=1.
// 3 card never drives MISO low after CMD55 -> error=1, err_code=1 after exactly 64 post-frame rise edges.
// 4 CMD55 R1=0x05 -> err_code=2; ACMD41 R1=0x04 (separate run) -> err_code=2; CMD58 R1=0x01 -> err_code=2.
// 5 R1 preceded by 3 idle bytes (0xFF) -> accepted; OCR 0x80FF8000 -> ccs=0, done=1.
// 6 input_rst pulsed mid-ACMD41 frame -> next cycle CS=1, SCLK=0, busy=0, tries=0; start pulse during busy ignored.

Source files
------------

// File: rtl/sd_acmd41_ready_if.sv
// sd_acmd41_ready_if: control, status and SPI pin bundle for the ACMD41/CMD58 init stage.
interface sd_acmd41_ready_if;
    logic        start;
    logic        MISO_bit;
    logic        SCLK_bit;
    logic        CS_bit;
    logic        MOSI_bit;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] ocr;
    logic        ccs;
    logic [15:0] tries;
    modport master (input start, MISO_bit,
                    output SCLK_bit, CS_bit, MOSI_bit, busy, done, error, err_code, ocr, ccs, tries);
    modport slave  (output start, MISO_bit,
                    input SCLK_bit, CS_bit, MOSI_bit, busy, done, error, err_code, ocr, ccs, tries);
endinterface

// File: rtl/sd_acmd41_ready.sv
// sd_acmd41_ready: SPI-mode SD init stage looping CMD55+ACMD41 until ready, then reading OCR via CMD58.
module sd_acmd41_ready #(
    parameter int CLK_DIV   = 100,
    parameter int MAX_TRIES = 1000,
    parameter int NCR_BITS  = 64,
    parameter int GAP_BITS  = 8
) (
    input logic input_clk,
    input logic input_rst,
    sd_acmd41_ready_if.master io_bus
);
    typedef enum logic [2:0] {S_IDLE, S_TX, S_R1, S_OCR, S_GAP, S_DONE, S_FAIL} state_t;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [47:0] F55 = 48'h770000000065;
    localparam logic [47:0] F41 = 48'h694000000077;
    localparam logic [47:0] F58 = 48'h7A00000000FD;

    state_t      r_state;
    logic [DW-1:0] r_div;
    logic        r_sclk, r_cs, r_mosi, r_busy, r_done, r_error, r_started, r_ccs;
    logic [1:0]  r_cmd, r_err;
    logic [7:0]  r_cnt, r_rx;
    logic [47:0] r_sh;
    logic [31:0] r_ocr;
    logic [15:0] r_tries;
    logic        w_wrap, w_rise, w_fall;
    logic [1:0]  w_code;
    logic [15:0] w_tries_n;
    logic [47:0] w_frame;

    assign w_wrap    = r_busy && r_div == DW'(CLK_DIV - 1);
    assign w_rise    = w_wrap && !r_sclk;
    assign w_fall    = w_wrap && r_sclk;
    assign w_tries_n = r_tries == 16'(MAX_TRIES) ? r_tries : r_tries + 16'd1;
    assign w_frame   = r_cmd == 2'd0 ? F55 : r_cmd == 2'd1 ? F41 : F58;
    // r_cmd selects which response rules apply: 0 CMD55, 1 ACMD41, 2 CMD58
    assign w_code = r_cmd == 2'd0 ? (r_rx[7:1] == 7'd0 ? 2'd0 : 2'd2)
                  : r_cmd == 2'd1 ? (r_rx == 8'h00 ? 2'd0 : r_rx != 8'h01 ? 2'd2
                                     : w_tries_n == 16'(MAX_TRIES) ? 2'd3 : 2'd0)
                  : (r_rx == 8'h00 ? 2'd0 : 2'd2);

    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err     <= 2'd0;
            r_started <= 1'b0;
            r_ccs     <= 1'b0;
            r_cmd     <= 2'd0;
            r_cnt     <= 8'd0;
            r_rx      <= 8'd0;
            r_sh      <= '1;
            r_ocr     <= 32'd0;
            r_tries   <= 16'd0;
        end else begin
            r_div <= (w_wrap || !r_busy) ? '0 : r_div + DW'(1);
            if (w_wrap) r_sclk <= !r_sclk;
            if (w_fall && r_state != S_TX) r_mosi <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: if (io_bus.start) begin
                    r_state <= S_TX;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_err   <= 2'd0;
                    r_tries <= 16'd0;
                    r_ocr   <= 32'd0;
                    r_ccs   <= 1'b0;
                    r_cmd   <= 2'd0;
                    r_cnt   <= 8'd0;
                    r_div   <= '0;
                    r_sclk  <= 1'b0;
                    r_cs    <= 1'b0;
                    r_mosi  <= F55[47];
                    r_sh    <= {F55[46:0], 1'b1};
                end
                S_TX: begin
                    if (w_rise) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'd47) begin
                            r_state   <= S_R1;
                            r_cnt     <= 8'd0;
                            r_started <= 1'b0;
                        end
                    end
                    if (w_fall) begin
                        r_mosi <= r_sh[47];
                        r_sh   <= {r_sh[46:0], 1'b1};
                    end
                end
                S_R1: begin
                    if (w_rise) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_started || !io_bus.MISO_bit) r_rx <= {r_rx[6:0], io_bus.MISO_bit};
                        if (!r_started && !io_bus.MISO_bit) begin
                            r_started <= 1'b1;
                            r_cnt     <= 8'd1;
                        end
                    end
                    // decisions wait for the falling edge so SCLK always stops low
                    if (w_fall && !r_started && r_cnt == 8'(NCR_BITS)) begin
                        r_state <= S_FAIL;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_err   <= 2'd1;
                        r_cs    <= 1'b1;
                    end
                    if (w_fall && r_started && r_cnt == 8'd8) begin
                        if (r_cmd == 2'd1) r_tries <= w_tries_n;
                        r_cnt <= 8'd0;
                        if (w_code != 2'd0) begin
                            r_state <= S_FAIL;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                            r_err   <= w_code;
                            r_cs    <= 1'b1;
                        end else if (r_cmd == 2'd2) begin
                            r_state <= S_OCR;
                        end else begin
                            r_state <= S_GAP;
                            r_cs    <= 1'b1;
                            r_cmd   <= (r_cmd == 2'd0 || r_rx == 8'h00) ? r_cmd + 2'd1 : 2'd0;
                        end
                    end
                end
                S_OCR: begin
                    if (w_rise) begin
                        r_cnt <= r_cnt + 8'd1;
                        r_sh  <= {r_sh[46:0], io_bus.MISO_bit};
                    end
                    if (w_fall && r_cnt == 8'd32) begin
                        r_ocr   <= r_sh[31:0];
                        r_ccs   <= r_sh[30];
                        r_state <= S_GAP;
                        r_cmd   <= 2'd3;
                        r_cs    <= 1'b1;
                        r_cnt   <= 8'd0;
                    end
                end
                S_GAP: begin
                    if (w_rise) r_cnt <= r_cnt + 8'd1;
                    // r_cmd==3 marks the trailing clocks after OCR
                    if (w_fall && r_cnt == 8'(GAP_BITS)) begin
                        r_cnt <= 8'd0;
                        if (r_cmd == 2'd3) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_TX;
                            r_cs    <= 1'b0;
                            r_mosi  <= w_frame[47];
                            r_sh    <= {w_frame[46:0], 1'b1};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.SCLK_bit = r_sclk;
    assign io_bus.CS_bit   = r_cs;
    assign io_bus.MOSI_bit = r_mosi;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.error    = r_error;
    assign io_bus.err_code = r_err;
    assign io_bus.ocr      = r_ocr;
    assign io_bus.ccs      = r_ccs;
    assign io_bus.tries    = r_tries;
endmodule
